// File: rtl/io_console_bank_if.sv
// rtl/io_console_bank_if.sv - CPU bus bundle between the bus mux and the console bank
interface io_console_bank_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] address;
    logic [7:0]        Din;
    logic [7:0]        Dout;
    logic              WE;
    logic              RE;
    logic              IO_sel;

    modport master (output address, Din, WE, RE, input Dout, IO_sel);
    modport slave  (input address, Din, WE, RE, output Dout, IO_sel);
endinterface

// File: rtl/io_console_bank.sv
// rtl/io_console_bank.sv - multi-console Atom I/O block: PIO, VIA-lite timer and palette per console
module io_console_bank #(
    parameter int CONSOLES = 4,
    parameter int PALETTE  = 4,
    parameter int COLOR_W  = 6,
    parameter int ADDR_W   = 19,
    localparam int SEL_W   = (CONSOLES > 1) ? $clog2(CONSOLES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    io_console_bank_if.slave           bus,
    input  logic                       tick,
    input  logic [9:0]                 PIOinput,
    input  logic [SEL_W-1:0]           active,
    input  logic [SEL_W-1:0]           visible,
    output logic [3:0]                 key_row,
    output logic [3:0]                 gmod,
    output logic [PALETTE*COLOR_W-1:0] colors,
    output logic [CONSOLES-1:0]        irq
);
    localparam int PAL_W = $clog2(PALETTE);

    logic [SEL_W-1:0] c;
    logic [1:0]       region;
    logic [3:0]       off;
    logic             wr, pio_wr, via_wr, vga_wr;

    assign c          = bus.address[16 +: SEL_W];
    assign region     = bus.address[11:10];
    assign off        = bus.address[3:0];
    assign bus.IO_sel = (bus.address[15:12] == 4'hB);
    assign wr         = bus.IO_sel & bus.WE;
    assign pio_wr     = wr & (region == 2'd0);
    assign via_wr     = wr & (region == 2'd2);
    assign vga_wr     = wr & (region == 2'd3);

    logic unused_addr;
    assign unused_addr = ^bus.address;

    logic [3:0]         krow     [CONSOLES];
    logic [3:0]         gmode    [CONSOLES];
    logic [3:0]         pcl      [CONSOLES];
    logic [7:0]         latch_lo [CONSOLES];
    logic [7:0]         latch_hi [CONSOLES];
    logic [7:0]         acr      [CONSOLES];
    logic [15:0]        counter  [CONSOLES];
    logic [COLOR_W-1:0] pal      [CONSOLES][PALETTE];
    logic [CONSOLES-1:0] running, ifr, ier;
    logic [CONSOLES-1:0] sel, t1h, fire, ifr_clr;

    // A T1H write owns the timer for that cycle, so a coincident tick neither counts nor fires.
    always_comb begin
        sel     = '0;
        t1h     = '0;
        fire    = '0;
        ifr_clr = '0;
        for (int i = 0; i < CONSOLES; i++) begin
            sel[i]     = (c == SEL_W'(i));
            t1h[i]     = via_wr & sel[i] & (off == 4'd5);
            fire[i]    = tick & running[i] & (counter[i] == 16'd0) & ~t1h[i];
            ifr_clr[i] = sel[i] & bus.IO_sel & (region == 2'd2) &
                         ((bus.RE & (off == 4'd4)) | (bus.WE & (off == 4'd6) & bus.Din[6]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gmod    <= '0;
            running <= '0;
            ifr     <= '0;
            ier     <= '0;
            for (int i = 0; i < CONSOLES; i++) begin
                krow[i]     <= 4'hF;
                gmode[i]    <= '0;
                pcl[i]      <= '0;
                latch_lo[i] <= '0;
                latch_hi[i] <= '0;
                acr[i]      <= '0;
                counter[i]  <= '0;
                for (int k = 0; k < PALETTE; k++)
                    pal[i][k] <= (k == 0) ? COLOR_W'(3) : '1;
            end
        end else begin
            gmod <= gmode[visible];
            for (int i = 0; i < CONSOLES; i++) begin
                if (pio_wr && sel[i]) begin
                    case (off[1:0])
                        2'd0:    {gmode[i], krow[i]} <= bus.Din;
                        2'd2:    pcl[i] <= bus.Din[3:0];
                        default: ;
                    endcase
                end
                if (via_wr && sel[i]) begin
                    case (off)
                        4'd4:    latch_lo[i] <= bus.Din;
                        4'd7:    if (bus.Din[6]) ier[i] <= bus.Din[7];
                        4'd11:   acr[i] <= bus.Din;
                        default: ;
                    endcase
                end
                if (t1h[i]) begin
                    latch_hi[i] <= bus.Din;
                    counter[i]  <= {bus.Din, latch_lo[i]};
                    running[i]  <= 1'b1;
                end else if (tick && running[i]) begin
                    if (counter[i] != 16'd0)
                        counter[i] <= counter[i] - 16'd1;
                    else if (acr[i][6])
                        counter[i] <= {latch_hi[i], latch_lo[i]};
                    else
                        running[i] <= 1'b0;
                end
                // Underflow beats a software clear landing in the same cycle.
                if (t1h[i])
                    ifr[i] <= 1'b0;
                else if (fire[i])
                    ifr[i] <= 1'b1;
                else if (ifr_clr[i])
                    ifr[i] <= 1'b0;
                if (vga_wr && sel[i]) begin
                    for (int k = 0; k < PALETTE; k++)
                        if (off == 4'(k)) pal[i][k] <= bus.Din[COLOR_W-1:0];
                end
            end
        end
    end

    assign irq     = ifr & ier;
    assign key_row = krow[active];

    logic [7:0] pal_rd;
    always_comb begin
        bus.Dout = 8'h00;
        pal_rd   = 8'h00;
        if (bus.IO_sel) begin
            case (region)
                2'd0: begin
                    case (off[1:0])
                        2'd0:    bus.Dout = {gmode[c], krow[c]};
                        2'd1:    bus.Dout = (c == active) ? PIOinput[7:0] : 8'hFF;
                        2'd2:    bus.Dout = {PIOinput[9:8], 2'b11, pcl[c]};
                        default: bus.Dout = 8'hFF;
                    endcase
                end
                2'd1: bus.Dout = 8'h00;
                2'd2: begin
                    case (off)
                        4'd4:    bus.Dout = counter[c][7:0];
                        4'd5:    bus.Dout = counter[c][15:8];
                        4'd6:    bus.Dout = {irq[c], ifr[c], 6'b0};
                        4'd7:    bus.Dout = {1'b1, ier[c], 6'b0};
                        4'd11:   bus.Dout = acr[c];
                        default: bus.Dout = 8'hFF;
                    endcase
                end
                default: begin
                    if ({28'd0, off} < PALETTE) begin
                        pal_rd[COLOR_W-1:0] = pal[c][off[PAL_W-1:0]];
                        bus.Dout = pal_rd;
                    end else begin
                        bus.Dout = 8'hFF;
                    end
                end
            endcase
        end
    end

    // Entry 0 is the border colour; it is blanked while the viewer also owns the keyboard.
    always_comb begin
        colors = '0;
        for (int k = 0; k < PALETTE; k++)
            colors[(PALETTE-1-k)*COLOR_W +: COLOR_W] =
                (k == 0 && visible == active) ? '0 : pal[visible][k];
    end
endmodule

// File: tb/tb_io_console_bank.sv
// tb/tb_io_console_bank.sv - scoreboard bench for io_console_bank
module tb_io_console_bank;
    logic        clk;
    logic        reset;
    logic        tick;
    logic [9:0]  PIOinput;
    logic [1:0]  active, visible;
    logic [3:0]  key_row, gmod;
    logic [23:0] colors;
    logic [3:0]  irq;

    io_console_bank_if #(.ADDR_W(19)) bus ();

    io_console_bank #(.CONSOLES(4), .PALETTE(4), .COLOR_W(6), .ADDR_W(19)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tick(tick), .PIOinput(PIOinput),
        .active(active), .visible(visible), .key_row(key_row), .gmod(gmod),
        .colors(colors), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    logic        probe;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (bus.RE || probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: output strobe with no expected entry");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = {24'd0, bus.Dout};
                    1:       act = {28'd0, key_row};
                    2:       act = {28'd0, gmod};
                    3:       act = {28'd0, irq};
                    default: act = {8'd0, colors};
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d,
                      input logic t = 1'b0);
        bus.address = {1'b0, c, a};
        bus.Din     = d;
        bus.WE      = 1'b1;
        tick        = t;
        @(posedge clk); #1;
        bus.WE      = 1'b0;
        tick        = 1'b0;
    endtask

    task automatic rd(input logic [1:0] c, input logic [15:0] a, input logic [7:0] x,
                      input string n);
        sb.push_back('{0, {24'd0, x}, n});
        bus.address = {1'b0, c, a};
        bus.RE      = 1'b1;
        @(posedge clk); #1;
        bus.RE      = 1'b0;
    endtask

    task automatic chk(input int k, input logic [31:0] x, input string n);
        sb.push_back('{k, x, n});
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tick = 1'b0; probe = 1'b0;
        PIOinput = 10'h2C5; active = 2'd0; visible = 2'd0;
        bus.address = '0; bus.Din = '0; bus.WE = 1'b0; bus.RE = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        chk(1, 32'hF, "reset_key_row");
        chk(2, 32'h0, "reset_gmod");
        chk(3, 32'h0, "reset_irq");
        chk(4, 32'h03FFFF, "reset_colors_same");
        visible = 2'd1;
        chk(4, 32'h0FFFFF, "reset_colors_other");
        rd(2'd0, 16'hB000, 8'h0F, "pio0_reset");

        wr(2'd2, 16'hB000, 8'h5A);
        visible = 2'd2;
        @(posedge clk); #1;
        chk(2, 32'h5, "gmod_c2");
        rd(2'd0, 16'hB000, 8'h0F, "pio0_c0_untouched");
        rd(2'd2, 16'hB000, 8'h5A, "pio0_c2");
        active = 2'd2;
        chk(1, 32'hA, "key_row_c2");

        active = 2'd1;
        rd(2'd1, 16'hB001, 8'hC5, "pio1_active");
        rd(2'd3, 16'hB001, 8'hFF, "pio1_inactive");
        wr(2'd1, 16'hB002, 8'h07);
        rd(2'd1, 16'hB002, 8'hB7, "pio2");
        rd(2'd1, 16'hB003, 8'hFF, "pio3");
        rd(2'd0, 16'hB400, 8'h00, "ext_region");
        rd(2'd0, 16'hB803, 8'hFF, "via_other");
        rd(2'd0, 16'hA000, 8'h00, "not_io");

        wr(2'd0, 16'hB807, 8'hC0);
        wr(2'd0, 16'hB804, 8'h03);
        wr(2'd0, 16'hB805, 8'h00);
        rd(2'd0, 16'hB807, 8'hC0, "ier_read");
        tk(3);
        chk(3, 32'h0, "oneshot_before");
        tk(1);
        chk(3, 32'h1, "oneshot_fire");
        rd(2'd0, 16'hB804, 8'h00, "oneshot_cnt_lo");
        chk(3, 32'h0, "oneshot_re_clear");
        tk(2);
        chk(3, 32'h0, "oneshot_stopped");
        rd(2'd0, 16'hB805, 8'h00, "oneshot_cnt_hi");

        wr(2'd1, 16'hB80B, 8'h40);
        wr(2'd1, 16'hB807, 8'hC0);
        wr(2'd1, 16'hB804, 8'h02);
        wr(2'd1, 16'hB805, 8'h00);
        tk(2);
        chk(3, 32'h0, "free_before");
        tk(1);
        chk(3, 32'h2, "free_fire1");
        rd(2'd1, 16'hB806, 8'hC0, "ifr_read");
        rd(2'd1, 16'hB80B, 8'h40, "acr_read");
        wr(2'd1, 16'hB806, 8'h40);
        chk(3, 32'h0, "ifr_write_clear");
        tk(2);
        wr(2'd1, 16'hB806, 8'h40, 1'b1);
        chk(3, 32'h2, "set_beats_clear");
        wr(2'd1, 16'hB806, 8'h40);
        chk(3, 32'h0, "clear_again");
        tk(1);
        wr(2'd1, 16'hB805, 8'h00, 1'b1);
        rd(2'd1, 16'hB804, 8'h02, "t1h_beats_tick");
        rd(2'd1, 16'hB805, 8'h00, "t1h_hi");
        tk(2);
        chk(3, 32'h0, "free_period_pre");
        tk(1);
        chk(3, 32'h2, "free_period");

        wr(2'd1, 16'hB804, 8'h00);
        wr(2'd1, 16'hB805, 8'h00);
        chk(3, 32'h0, "latch0_armed");
        tk(1);
        chk(3, 32'h2, "latch0_fire1");
        wr(2'd1, 16'hB806, 8'h40);
        chk(3, 32'h0, "latch0_clear");
        tk(1);
        chk(3, 32'h2, "latch0_fire2");

        wr(2'd3, 16'hBC02, 8'h15);
        rd(2'd3, 16'hBC02, 8'h15, "pal_rw");
        rd(2'd3, 16'hBC00, 8'h03, "pal_entry0");
        rd(2'd3, 16'hBC05, 8'hFF, "pal_oob");
        rd(2'd0, 16'hBC02, 8'h3F, "pal_c0_untouched");
        visible = 2'd3;
        chk(4, 32'h0FF57F, "colors_c3");

        wr(2'd0, 16'hB804, 8'h10);
        wr(2'd0, 16'hB805, 8'h00);
        tk(2);
        rd(2'd0, 16'hB804, 8'h0E, "midcount");
        reset = 1'b0;
        rd(2'd0, 16'hB804, 8'h00, "reset_counter");
        chk(3, 32'h0, "reset_irq_mid");
        rd(2'd3, 16'hBC02, 8'h3F, "reset_palette");
        reset = 1'b1;
        tk(1);
        rd(2'd0, 16'hB804, 8'h00, "tick_after_reset");
        chk(4, 32'h0FFFFF, "colors_after_reset");
        chk(1, 32'hF, "key_row_after_reset");

        @(posedge clk); #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_console_bank.md
Name: io_console_bank

Overview:
Parametrised successor to the single-bank Atom I/O decoder. It serves CONSOLES independent virtual Atoms sharing one CPU bus, with console selected by address bits above bit 15. Each console has an 8255-style PIO, a 6522-style VIA-lite (16-bit Timer 1 with one-shot/free-run modes and IRQ), and a readable/writable palette of PALETTE entries. It sits between the CPU bus mux and the keyboard scanner / VGA generator.

Parameters:
CONSOLES, 4, number of consoles; power of two, 1..8; SEL_W = max(1, clog2(CONSOLES)) is derived locally.
PALETTE, 4, palette entries per console (2..16).
COLOR_W, 6, bits per palette entry, RGB 2:2:2 at the default.
ADDR_W, 19, bus address width; must be at least 16+SEL_W.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
address  in  ADDR_W  CPU address; [15:12]==4'hB selects I/O; [16+SEL_W-1:16] selects the console
Din  in  8  write data
Dout  out  8  combinational read data
WE  in  1  single-cycle write strobe
RE  in  1  single-cycle read strobe; qualifies read side effects only
tick  in  1  timer prescale strobe, 1 MHz equivalent, one clk wide
IO_sel  out  1  high when address[15:12]==4'hB
PIOinput  in  10  [7:0] keyboard columns/CTRL/SHIFT; [9:8] vsync/REPT
active  in  SEL_W  console that owns the keyboard
visible  in  SEL_W  console shown on VGA
key_row  out  4  keyboard row of the active console
gmod  out  4  graphics mode of the visible console, registered
colors  out  PALETTE*COLOR_W  palette of the visible console; entry 0 is in the MS slice
irq  out  CONSOLES  per-console timer interrupt (IFR6 & IER6)

Behaviour:
- Decode on address[11:10]: 0 PIO, 1 extension, 2 VIA, 3 VGAIO. c = console select field. wr = IO_sel & WE.
- PIO (address[1:0]):
  - 0: R/W {gmode[c], krow[c]}.
  - 1: R PIOinput[7:0] if c==active, else 8'hFF.
  - 2: W Port_C_low[c] <= Din[3:0]; R {PIOinput[9:8], 2'b11, Port_C_low[c]}.
  - 3: R 8'hFF.
- VIA (address[3:0]):
  - 4: W latch_lo. R counter[7:0]; RE clears IFR6.
  - 5: W latch_hi <= Din, counter <= {Din, latch_lo}, running <= 1, IFR6 <= 0. R counter[15:8].
  - 6: R {irq[c], IFR6, 6'b0}; W bits set in Din[6] clear IFR6.
  - 7: W Din[7]=1 sets IER6 if Din[6], Din[7]=0 clears it. R {1'b1, IER6, 6'b0}.
  - 11 (ACR): R/W, bit6 = free-run.
  - Any other offset reads 8'hFF.
- Timer, per console, all consoles in parallel on tick while running:
  - counter != 0: decrement.
  - counter == 0: IFR6 <= 1; in free-run, counter <= {latch_hi, latch_lo}; in one-shot, running <= 0 and counter holds 0.
- Timer conflicts:
  - A T1H write in the same cycle as a tick: the write wins and that tick is ignored.
  - An IFR set and a clear in the same cycle: the set wins.
- Latch value 0 in free-run fires on every tick.
- VGAIO: address[3:0] < PALETTE is R/W pal[c][n] using Din[COLOR_W-1:0]; reads are zero-extended; other offsets read 8'hFF.
- Extension region: reads 8'h00, writes ignored.
- Dout = 8'h00 when IO_sel is low.
- colors: entry 0 is forced to 0 when visible==active; the other entries pass through combinationally.
- gmod <= gmode[visible] every clk (1-cycle latency). key_row = krow[active], combinational.
- Reset, asynchronous, all consoles:
  - krow = 4'hF; gmode, Port_C_low, latches, counters, ACR, IFR, IER = 0; running = 0; gmod = 0.
  - pal entry 0 = 3; other entries all-ones. irq = 0.
- Reset asserted mid-count aborts the timer immediately. The first tick after deassert has no effect until a T1H write.
- Writes only modify console c; other consoles are untouched.

Test Plan:
- Reset: check key_row=4'hF, gmod=0, irq=0, colors default with entry 0 = 0 for visible==active; change visible to 1 -> entry 0 = 6'h03.
- Write 8'h5A to #B000 for console 2, then visible=2 -> gmod=4'h5 one clk later; console 0 readback unchanged (8'h0F).
- active=1: read #B001 for console 1 -> PIOinput[7:0]; read for console 3 -> 8'hFF.
- Console 0: IER=8'hC0, latch 8'h0003, one-shot, 4 ticks -> irq[0] rises on the 4th tick; counter holds 0; reading #B804 with RE clears irq[0].
- Free-run with latch 2: irq sets every 3 ticks; a clear at #B806 coinciding with underflow leaves IFR6=1; a T1H write coinciding with a tick reloads and ignores the tick.
- Write palette entry 2 = 6'h15 on console 3 and read it back as 8'h15; assert reset mid-count -> counter=0, irq=0, palette restored.
